// File: rtl/tteframe_ingress.sv
// Ingress buffer for the TTE frame processor: CRC/length/rx_er screening of a GMII byte stream,
// good frames kept FCS-stripped in a byte RAM and announced through a length pointer FIFO.
module tteframe_ingress #(
  parameter int DATA_AW   = 12,
  parameter int PTR_AW    = 4,
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rx_data,
  input  logic        sfifo_rd,
  output logic [7:0]  sfifo_dout,
  input  logic        ptr_sfifo_rd,
  output logic [15:0] ptr_sfifo_dout,
  output logic        ptr_sfifo_empty,
  output logic [15:0] frm_good_cnt,
  output logic [15:0] frm_drop_cnt
);

  localparam int DEPTH  = 2**DATA_AW;
  localparam int PDEPTH = 2**PTR_AW;
  localparam logic [DATA_AW:0]   DEPTH_V = DEPTH[DATA_AW:0];
  localparam logic [DATA_AW:0]   MAXF_V  = MAX_FRAME[DATA_AW:0];
  localparam logic [10:0]        MAXB    = MAX_FRAME[10:0];
  localparam logic [10:0]        MINB    = MIN_FRAME[10:0];
  localparam logic [PTR_AW:0]    PFULL   = PDEPTH[PTR_AW:0];
  localparam logic [DATA_AW-1:0] A_ONE   = {{(DATA_AW-1){1'b0}}, 1'b1};
  localparam logic [PTR_AW-1:0]  P_ONE   = {{(PTR_AW-1){1'b0}}, 1'b1};
  localparam logic [PTR_AW:0]    C_ONE   = {{PTR_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_DROP = 2'd2} state_t;

  // Reflected CRC32 (poly 0x04C11DB7), LSB of each byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ 32'hEDB88320;
      else      r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic [7:0]         mem_q  [DEPTH];
  logic [10:0]        pmem_q [PDEPTH];

  state_t             state_q, state_d;
  logic [DATA_AW-1:0] wr_q, wr_d, wr_base_q, wr_base_d, rd_q;
  logic [10:0]        bcnt_q, bcnt_d, len_s;
  logic [31:0]        crc_q, crc_d;
  logic               er_q, er_d, prev_dv_q;
  logic [PTR_AW:0]    pcnt_q, pcnt_d;
  logic [PTR_AW-1:0]  pw_q, pr_q;
  logic [7:0]         sfifo_dout_q;
  logic [15:0]        ptr_dout_q, good_cnt_q, drop_cnt_q;
  logic               empty_q;

  logic [DATA_AW-1:0] used_s;
  logic [DATA_AW:0]   free_s;
  logic               space_ok_s, frame_good_s, rd_en_s, pop_s;
  logic               we_s, push_s, good_s, drop_s;

  assign used_s  = wr_base_q - rd_q;
  assign free_s  = DEPTH_V - {1'b0, used_s};
  // prev_dv_q blocks a start on a frame already in flight (e.g. at reset release)
  assign space_ok_s   = (free_s >= MAXF_V) && (pcnt_q != PFULL) && !prev_dv_q;
  assign frame_good_s = (bcnt_q >= MINB) && (bcnt_q <= MAXB) && !er_q &&
                        (bitrev32(crc_q) == 32'hC704DD7B);
  assign len_s   = bcnt_q - 11'd4;
  assign rd_en_s = sfifo_rd && (rd_q != wr_base_q);
  assign pop_s   = ptr_sfifo_rd && (pcnt_q != {(PTR_AW+1){1'b0}});

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_dv) state_d = space_ok_s ? S_RECV : S_DROP;
               else       state_d = S_IDLE;
      S_RECV:  if (!rx_dv)             state_d = S_IDLE;
               else if (bcnt_q == MAXB) state_d = S_DROP;
               else                     state_d = S_RECV;
      S_DROP:  if (!rx_dv) state_d = S_IDLE;
               else        state_d = S_DROP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d      = wr_q;
    wr_base_d = wr_base_q;
    bcnt_d    = bcnt_q;
    crc_d     = crc_q;
    er_d      = er_q;
    we_s      = 1'b0;
    push_s    = 1'b0;
    good_s    = 1'b0;
    drop_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_RECV) begin
          we_s   = 1'b1;
          wr_d   = wr_q + A_ONE;
          bcnt_d = 11'd1;
          crc_d  = crc32_byte(32'hFFFFFFFF, rx_data);
          er_d   = rx_er;
        end else begin
          wr_d = wr_base_q;
        end
      end
      S_RECV: begin
        if (rx_dv) begin
          if (bcnt_q != MAXB) begin
            we_s   = 1'b1;
            wr_d   = wr_q + A_ONE;
            bcnt_d = bcnt_q + 11'd1;
            crc_d  = crc32_byte(crc_q, rx_data);
            er_d   = er_q | rx_er;
          end else begin
            wr_d = wr_base_q;
          end
        end else if (frame_good_s) begin
          // FCS bytes beyond wr_base are simply overwritten by the next frame
          push_s    = 1'b1;
          good_s    = 1'b1;
          wr_base_d = wr_base_q + DATA_AW'(len_s);
          wr_d      = wr_base_q + DATA_AW'(len_s);
        end else begin
          drop_s = 1'b1;
          wr_d   = wr_base_q;
        end
      end
      S_DROP: begin
        wr_d   = wr_base_q;
        drop_s = !rx_dv;
      end
      default: wr_d = wr_base_q;
    endcase
  end

  always_comb begin
    case ({push_s, pop_s})
      2'b10:   pcnt_d = pcnt_q + C_ONE;
      2'b01:   pcnt_d = pcnt_q - C_ONE;
      default: pcnt_d = pcnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_q         <= '0;
      wr_base_q    <= '0;
      rd_q         <= '0;
      bcnt_q       <= 11'd0;
      crc_q        <= 32'hFFFFFFFF;
      er_q         <= 1'b0;
      prev_dv_q    <= 1'b1;
      pcnt_q       <= '0;
      pw_q         <= '0;
      pr_q         <= '0;
      sfifo_dout_q <= 8'h00;
      ptr_dout_q   <= 16'h0000;
      empty_q      <= 1'b1;
      good_cnt_q   <= 16'h0000;
      drop_cnt_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      wr_base_q <= wr_base_d;
      bcnt_q    <= bcnt_d;
      crc_q     <= crc_d;
      er_q      <= er_d;
      prev_dv_q <= rx_dv;
      pcnt_q    <= pcnt_d;
      empty_q   <= (pcnt_d == {(PTR_AW+1){1'b0}});
      if (push_s) pw_q <= pw_q + P_ONE;
      if (pop_s) begin
        ptr_dout_q <= {5'b00000, pmem_q[pr_q]};
        pr_q       <= pr_q + P_ONE;
      end
      if (rd_en_s) begin
        sfifo_dout_q <= mem_q[rd_q];
        rd_q         <= rd_q + A_ONE;
      end
      if (good_s && (good_cnt_q != 16'hFFFF)) good_cnt_q <= good_cnt_q + 16'd1;
      if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // Storage arrays carry no reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (we_s)   mem_q[wr_q]   <= rx_data;
    if (push_s) pmem_q[pw_q]  <= len_s;
  end

  assign sfifo_dout      = sfifo_dout_q;
  assign ptr_sfifo_dout  = ptr_dout_q;
  assign ptr_sfifo_empty = empty_q;
  assign frm_good_cnt    = good_cnt_q;
  assign frm_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_tteframe_ingress.sv
// Directed + randomized bench for tteframe_ingress against a queue-based frame model.
module tb_tteframe_ingress;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0, rx_er = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        sfifo_rd = 1'b0, ptr_sfifo_rd = 1'b0;
  logic [7:0]  sfifo_dout;
  logic [15:0] ptr_sfifo_dout, frm_good_cnt, frm_drop_cnt;
  logic        ptr_sfifo_empty;

  tteframe_ingress dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
    .sfifo_rd(sfifo_rd), .sfifo_dout(sfifo_dout),
    .ptr_sfifo_rd(ptr_sfifo_rd), .ptr_sfifo_dout(ptr_sfifo_dout),
    .ptr_sfifo_empty(ptr_sfifo_empty),
    .frm_good_cnt(frm_good_cnt), .frm_drop_cnt(frm_drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: committed-but-unread frames as lengths plus their payload bytes in order.
  int          exp_len[$];
  logic [7:0]  exp_data[$];
  logic [7:0]  tx_q[$];
  int          m_good = 0, m_drop = 0;
  logic [15:0] last_ptr = 16'h0000;
  logic [7:0]  last_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic make_frame(input int total, input bit bad_crc);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    logic        fb;
    tx_q.delete();
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < total - 4; i++) begin
      b = 8'($urandom_range(0, 255));
      tx_q.push_back(b);
      for (int k = 0; k < 8; k++) begin
        fb  = crc[0] ^ b[k];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) tx_q.push_back(fcs[8*k +: 8]);
    if (bad_crc) tx_q[total-1] = tx_q[total-1] ^ 8'h10;
  endtask

  task automatic drive_bytes(input int from, input int upto, input int er_pos);
    for (int i = from; i < upto; i++) begin
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_data = tx_q[i];
      rx_er   = (i == er_pos);
    end
  endtask

  task automatic finish_frame();
    @(negedge clk);
    rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    @(negedge clk);
  endtask

  task automatic send_frame(input int total, input bit bad_crc, input int er_pos);
    int  used;
    bit  ok;
    make_frame(total, bad_crc);
    used = 0;
    foreach (exp_len[i]) used += exp_len[i];
    ok = (4096 - used >= 1518) && (exp_len.size() < 16) &&
         (total >= 64) && (total <= 1518) && !bad_crc && (er_pos < 0);
    if (ok) begin
      exp_len.push_back(total - 4);
      for (int i = 0; i < total - 4; i++) exp_data.push_back(tx_q[i]);
      m_good++;
    end else begin
      m_drop++;
    end
    drive_bytes(0, total, er_pos);
    finish_frame();
  endtask

  task automatic read_frame();
    int         len;
    int         bad;
    logic [7:0] e;
    chk("ptr_not_empty", 32'(ptr_sfifo_empty), 32'd0);
    len = exp_len.pop_front();
    ptr_sfifo_rd = 1'b1;
    @(negedge clk);
    ptr_sfifo_rd = 1'b0;
    chk("ptr_dout", 32'(ptr_sfifo_dout), 32'(len));
    last_ptr = 16'(len);
    bad = 0;
    sfifo_rd = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == len - 1) sfifo_rd = 1'b0;
      e = exp_data.pop_front();
      if (sfifo_dout !== e) bad++;
      last_byte = e;
    end
    chk("frame_data_mismatches", 32'(bad), 32'd0);
  endtask

  task automatic drain();
    while (exp_len.size() > 0) read_frame();
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_good_cnt"}, 32'(frm_good_cnt), 32'(m_good));
    chk({tag, "_drop_cnt"}, 32'(frm_drop_cnt), 32'(m_drop));
    chk({tag, "_empty"}, 32'(ptr_sfifo_empty), 32'(exp_len.size() == 0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(ptr_sfifo_empty), 32'd1);
    chk("rst_sfifo_dout", 32'(sfifo_dout), 32'd0);
    chk("rst_ptr_dout", 32'(ptr_sfifo_dout), 32'd0);
    chk("rst_good_cnt", 32'(frm_good_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(frm_drop_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 64B good frame -> pointer 0x003C
    send_frame(64, 1'b0, -1);
    check_status("good64");
    chk("good64_len", 32'(exp_len[0]), 32'h3C);
    read_frame();

    // corrupted FCS bit, then a good 100B frame
    send_frame(100, 1'b1, -1);
    send_frame(100, 1'b0, -1);
    check_status("badcrc");
    read_frame();
    check_status("badcrc_after_read");

    // runt and oversize
    send_frame(63, 1'b0, -1);
    send_frame(1519, 1'b0, -1);
    check_status("runt_oversize");

    // rx_er pulse mid-frame
    send_frame(200, 1'b0, 100);
    check_status("rx_er");

    // empty read side ignores strobes and holds outputs
    ptr_sfifo_rd = 1'b1;
    @(negedge clk);
    ptr_sfifo_rd = 1'b0;
    chk("ptr_hold_when_empty", 32'(ptr_sfifo_dout), 32'(last_ptr));
    sfifo_rd = 1'b1;
    @(negedge clk);
    sfifo_rd = 1'b0;
    chk("data_hold_when_empty", 32'(sfifo_dout), 32'(last_byte));

    // five max frames with no reads: space for two only
    for (int i = 0; i < 5; i++) send_frame(1518, 1'b0, -1);
    check_status("five_max");
    chk("five_max_pending", 32'(exp_len.size()), 32'd2);
    drain();
    send_frame(1518, 1'b0, -1);
    check_status("max_after_drain");
    drain();

    // pointer FIFO capacity: 17th small frame has no slot
    for (int i = 0; i < 17; i++) send_frame(64, 1'b0, -1);
    check_status("ptr_full");
    drain();

    // randomized traffic, wrapping the RAM several times
    for (int n = 0; n < 12; n++) begin
      int tot;
      tot = $urandom_range(60, 1520);
      send_frame(tot, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 50)) : -1);
      if ($urandom_range(0, 1) == 1) drain();
    end
    check_status("random");
    drain();

    // reset mid-frame with a committed frame pending, rx_dv held through release
    send_frame(64, 1'b0, -1);
    make_frame(300, 1'b0);
    drive_bytes(0, 100, -1);
    rst = 1'b1;
    drive_bytes(100, 103, -1);
    chk("midrst_empty", 32'(ptr_sfifo_empty), 32'd1);
    chk("midrst_good_cnt", 32'(frm_good_cnt), 32'd0);
    chk("midrst_drop_cnt", 32'(frm_drop_cnt), 32'd0);
    chk("midrst_ptr_dout", 32'(ptr_sfifo_dout), 32'd0);
    rst = 1'b0;
    exp_len.delete();
    exp_data.delete();
    m_good = 0;
    m_drop = 1;
    drive_bytes(103, 300, -1);
    finish_frame();
    check_status("after_rst_release");
    send_frame(80, 1'b0, -1);
    check_status("after_rst_good");
    read_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
